// File: rtl/rgb_pwm_axil_slave.sv
// rgb_pwm_axil_slave: AXI4-Lite register slave driving three PWM outputs from a shared prescaled phase counter
module rgb_pwm_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int PWM_RES = 8
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic                              pwm_r,
  output logic                              pwm_g,
  output logic                              pwm_b
);
  typedef enum logic [1:0] {W_IDLE, W_ADDR_HELD, W_DATA_HELD, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;
  w_state_t w_state, w_next;
  r_state_t r_state;
  logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
  logic [C_S_AXI_DATA_WIDTH-1:0] data_q, wr_data;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] strb_q, wr_strb;
  logic [1:0] addr_q, wr_addr;
  logic aw_hs, w_hs, ar_hs, do_write, tick;
  logic [7:0] pre;
  logic [PWM_RES-1:0] phase;
  logic unused_ok;
  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;
  assign tick = pre >= regs[3][15:8];
  assign S_AXI_BRESP = 2'b00;
  assign S_AXI_RRESP = 2'b00;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  always_comb begin
    wr_addr = (w_state == W_ADDR_HELD) ? addr_q : S_AXI_AWADDR[3:2];
    wr_data = (w_state == W_DATA_HELD) ? data_q : S_AXI_WDATA;
    wr_strb = (w_state == W_DATA_HELD) ? strb_q : S_AXI_WSTRB;
    do_write = (aw_hs | (w_state == W_ADDR_HELD)) & (w_hs | (w_state == W_DATA_HELD));
    w_next = do_write ? W_RESP :
             (w_state == W_RESP) ? (S_AXI_BREADY ? W_IDLE : W_RESP) :
             (w_state == W_IDLE && aw_hs) ? W_ADDR_HELD :
             (w_state == W_IDLE && w_hs) ? W_DATA_HELD : w_state;
  end
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY <= 1'b0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA <= '0;
      addr_q <= '0;
      data_q <= '0;
      strb_q <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      pre <= '0;
      phase <= '0;
      pwm_r <= 1'b0;
      pwm_g <= 1'b0;
      pwm_b <= 1'b0;
    end else begin
      w_state <= w_next;
      S_AXI_AWREADY <= (w_next == W_IDLE) | (w_next == W_DATA_HELD);
      S_AXI_WREADY <= (w_next == W_IDLE) | (w_next == W_ADDR_HELD);
      S_AXI_BVALID <= w_next == W_RESP;
      if (aw_hs) addr_q <= S_AXI_AWADDR[3:2];
      if (w_hs) begin
        data_q <= S_AXI_WDATA;
        strb_q <= S_AXI_WSTRB;
      end
      if (do_write)
        for (int i = 0; i < C_S_AXI_DATA_WIDTH/8; i++)
          if (wr_strb[i]) regs[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      if (ar_hs) begin
        r_state <= R_RESP;
        S_AXI_RDATA <= regs[S_AXI_ARADDR[3:2]];
        S_AXI_RVALID <= 1'b1;
        S_AXI_ARREADY <= 1'b0;
      end else if (r_state == R_RESP && S_AXI_RREADY) begin
        r_state <= R_IDLE;
        S_AXI_RVALID <= 1'b0;
        S_AXI_ARREADY <= 1'b1;
      end else begin
        S_AXI_ARREADY <= r_state == R_IDLE;
      end
      if (!regs[3][0]) begin
        pre <= '0;
        phase <= '0;
        pwm_r <= 1'b0;
        pwm_g <= 1'b0;
        pwm_b <= 1'b0;
      end else begin
        pre <= tick ? 8'd0 : pre + 8'd1;
        if (tick) phase <= phase + 1'b1;
        pwm_r <= phase < regs[0][PWM_RES-1:0];
        pwm_g <= phase < regs[1][PWM_RES-1:0];
        pwm_b <= phase < regs[2][PWM_RES-1:0];
      end
    end
  end
endmodule
